// File: rtl/posit_round_pipe.sv
// Posit encode-and-round stage: packs a normalised sign/scale/fraction tuple into an
// N-bit posit with runtime rounding mode, saturation and an elastic valid/ready pipe.
module posit_round_pipe #(
    parameter  int N        = 32,
    parameter  int ES       = 2,
    parameter  int NUM_PIPE = 2,
    parameter  int TAG_W    = 4,
    localparam int SW       = $clog2(N) + ES + 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             sign_i,
    input  logic             nar_i,
    input  logic             zero_i,
    input  logic [SW-1:0]    scale_i,
    input  logic [N-1:0]     mant_i,
    input  logic             sticky_i,
    input  logic [1:0]       rnd_mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N-1:0]     result_o,
    output logic             inexact_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int CW = ES + N + 2;
    localparam int WV = 2 * N + ES - 1;
    localparam logic signed [SW-1:0] K_MAX = SW'(N - 2);
    localparam logic signed [SW-1:0] K_MIN = SW'(-(N - 1));

    logic signed [SW-1:0] k;
    logic [SW-1:0]        sh;
    logic [CW-1:0]        content;
    logic signed [WV-1:0] wide;
    logic [N-2:0]         kept;
    logic                 g, s;
    logic [N-2:0]         a_mag;
    logic                 a_inc, a_inx;

    // Regime seed "10" (k >= 0) or "01" (k < 0) sits on top; an arithmetic shift by
    // k or ~k (= -k-1) replicates the leading bit into the full regime run.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        content = '0;
        k       = $signed(scale_i) >>> ES;
        sh      = k[SW-1] ? ~k : k;
        content[CW-1]   = ~k[SW-1];
        content[CW-2]   = k[SW-1];
        for (int i = 0; i < ES; i++) content[N+i] = scale_i[i];
        content[N-1:0]  = mant_i;
        wide  = $signed({content, {(N-3){1'b0}}}) >>> sh;
        kept  = wide[WV-1 -: N-1];
        g     = wide[WV-N];
        s     = (|wide[WV-N-1:0]) | sticky_i;

        case (rnd_mode_i)
            2'b00:   a_inc = g & (kept[0] | s);
            2'b01:   a_inc = 1'b0;
            2'b10:   a_inc = (g | s) & sign_i;
            default: a_inc = (g | s) & ~sign_i;
        endcase
        a_mag = kept;
        a_inx = g | s;

        if (k >= K_MAX) begin
            a_mag = '1;
            a_inc = 1'b0;
            a_inx = 1'b1;
        end else if (k <= K_MIN) begin
            a_mag = (N-1)'(1);
            a_inc = 1'b0;
            a_inx = 1'b1;
        end
        if (nar_i || zero_i) a_inx = 1'b0;
    end

    // Increment (never past maxpos), apply sign, then let specials override.
    function automatic logic [N-1:0] finish_res(input logic [N-2:0] mag, input logic inc,
                                                input logic nar, input logic zero,
                                                input logic sgn);
        logic [N-1:0] m;
        m = {1'b0, mag};
        if (inc && !(&mag)) m = m + N'(1);
        if (sgn) m = -m;
        if (nar) m = {1'b1, {(N-1){1'b0}}};
        else if (zero) m = '0;
        return m;
    endfunction

    if (NUM_PIPE == 1) begin : g_one
        logic             v_q, v_d;
        logic [N-1:0]     res_q;
        logic             inx_q;
        logic [TAG_W-1:0] tag_q;

        assign in_ready_o = !v_q || out_ready_i;
        assign v_d        = flush_i ? 1'b0 : (in_ready_o ? in_valid_i : v_q);

        // NOTE: payload registers are reset too, so result/inexact/tag read 0 out of reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_q   <= 1'b0;
                res_q <= '0;
                inx_q <= 1'b0;
                tag_q <= '0;
            end else begin
                v_q <= v_d;
                if (in_valid_i && in_ready_o) begin
                    res_q <= finish_res(a_mag, a_inc, nar_i, zero_i, sign_i);
                    inx_q <= a_inx;
                    tag_q <= tag_i;
                end
            end
        end

        assign out_valid_o = v_q;
        assign result_o    = res_q;
        assign inexact_o   = inx_q;
        assign tag_o       = tag_q;
    end else begin : g_two
        logic             s0_valid_q, s0_valid_d;
        logic [N-2:0]     s0_mag_q;
        logic             s0_inc_q, s0_inx_q, s0_nar_q, s0_zero_q, s0_sign_q;
        logic [TAG_W-1:0] s0_tag_q;
        logic             s1_valid_q, s1_valid_d;
        logic [N-1:0]     s1_res_q;
        logic             s1_inx_q;
        logic [TAG_W-1:0] s1_tag_q;
        logic             s1_ready, s0_adv;

        assign s1_ready   = !s1_valid_q || out_ready_i;
        assign s0_adv     = s0_valid_q && s1_ready;
        assign in_ready_o = !s0_valid_q || s0_adv;
        assign s0_valid_d = flush_i ? 1'b0 : (in_ready_o ? in_valid_i : s0_valid_q);
        assign s1_valid_d = flush_i ? 1'b0 : (s1_ready ? s0_valid_q : s1_valid_q);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s0_valid_q <= 1'b0;
                s0_mag_q   <= '0;
                s0_inc_q   <= 1'b0;
                s0_inx_q   <= 1'b0;
                s0_nar_q   <= 1'b0;
                s0_zero_q  <= 1'b0;
                s0_sign_q  <= 1'b0;
                s0_tag_q   <= '0;
                s1_valid_q <= 1'b0;
                s1_res_q   <= '0;
                s1_inx_q   <= 1'b0;
                s1_tag_q   <= '0;
            end else begin
                s0_valid_q <= s0_valid_d;
                s1_valid_q <= s1_valid_d;
                if (in_valid_i && in_ready_o) begin
                    s0_mag_q  <= a_mag;
                    s0_inc_q  <= a_inc;
                    s0_inx_q  <= a_inx;
                    s0_nar_q  <= nar_i;
                    s0_zero_q <= zero_i;
                    s0_sign_q <= sign_i;
                    s0_tag_q  <= tag_i;
                end
                if (s0_adv) begin
                    s1_res_q <= finish_res(s0_mag_q, s0_inc_q, s0_nar_q, s0_zero_q, s0_sign_q);
                    s1_inx_q <= s0_inx_q;
                    s1_tag_q <= s0_tag_q;
                end
            end
        end

        assign out_valid_o = s1_valid_q;
        assign result_o    = s1_res_q;
        assign inexact_o   = s1_inx_q;
        assign tag_o       = s1_tag_q;
    end

endmodule

// File: tb/tb_posit_round_pipe.sv
// Bench for posit_round_pipe: bit-list reference model + scoreboard, directed literal
// vectors, backpressure, flush and asynchronous reset scenarios.
module tb_posit_round_pipe;

    localparam int N        = 32;
    localparam int ES       = 2;
    localparam int NUM_PIPE = 2;
    localparam int TAG_W    = 4;
    localparam int SW       = $clog2(N) + ES + 3;

    logic             clk_i, rst_ni, flush_i;
    logic             in_valid_i, in_ready_o;
    logic             sign_i, nar_i, zero_i, sticky_i;
    logic [SW-1:0]    scale_i;
    logic [N-1:0]     mant_i;
    logic [1:0]       rnd_mode_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o, out_ready_i, inexact_o;
    logic [N-1:0]     result_o;
    logic [TAG_W-1:0] tag_o;

    typedef struct {
        logic [31:0]      res;
        logic             inx;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb[$];
    logic [TAG_W-1:0] got_tags[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [TAG_W-1:0] tag_ctr;

    posit_round_pipe #(.N(N), .ES(ES), .NUM_PIPE(NUM_PIPE), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .sign_i(sign_i), .nar_i(nar_i), .zero_i(zero_i), .scale_i(scale_i),
        .mant_i(mant_i), .sticky_i(sticky_i), .rnd_mode_i(rnd_mode_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .inexact_o(inexact_o), .tag_o(tag_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: lay the posit bits out as a plain bit list, then cut and round.
    function automatic logic [32:0] model(input logic sgn, input logic nar, input logic zro,
                                          input int scale, input logic [31:0] mant,
                                          input logic stk, input logic [1:0] mode);
        int          e, k;
        bit          q[$];
        logic [31:0] mag;
        logic        g, s, l, inc, inx;
        if (nar) return {1'b0, 32'h80000000};
        if (zro) return 33'h0;
        e = ((scale % 4) + 4) % 4;
        k = (scale - e) / 4;
        if (k >= 30) begin
            mag = 32'h7FFFFFFF;
            inx = 1'b1;
        end else if (k <= -31) begin
            mag = 32'h1;
            inx = 1'b1;
        end else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            q.push_back(e[1]);
            q.push_back(e[0]);
            for (int i = 31; i >= 0; i--) q.push_back(mant[i]);
            mag = 32'h0;
            for (int i = 0; i < 31; i++) mag = {mag[30:0], q[i]};
            l = q[30];
            g = q[31];
            s = stk;
            for (int i = 32; i < q.size(); i++) s = s | q[i];
            case (mode)
                2'd0:    inc = g & (l | s);
                2'd1:    inc = 1'b0;
                2'd2:    inc = (g | s) & sgn;
                default: inc = (g | s) & !sgn;
            endcase
            if (inc && mag != 32'h7FFFFFFF) mag = mag + 32'd1;
            inx = g | s;
        end
        return {inx, sgn ? -mag : mag};
    endfunction

    // Scoreboard: outputs checked against the model on every valid cycle, stalled or not.
    exp_t        m_ent;
    logic [32:0] m_r;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (out_valid_o) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", 1, 0);
                end else begin
                    m_ent = sb[0];
                    check("sb_result", result_o, m_ent.res);
                    check("sb_inexact", inexact_o, m_ent.inx);
                    check("sb_tag", tag_o, m_ent.tag);
                    if (out_ready_i) begin
                        void'(sb.pop_front());
                        got_tags.push_back(tag_o);
                    end
                end
            end
            if (flush_i) begin
                sb.delete();
            end else if (in_valid_i && in_ready_o) begin
                m_r = model(sign_i, nar_i, zero_i, int'($signed(scale_i)), mant_i,
                            sticky_i, rnd_mode_i);
                m_ent.res = m_r[31:0];
                m_ent.inx = m_r[32];
                m_ent.tag = tag_i;
                sb.push_back(m_ent);
            end
        end
    end

    always @(negedge rst_ni) sb.delete();

    task automatic set_op(input logic sgn, input logic nar, input logic zro, input int scale,
                          input logic [31:0] mant, input logic stk, input logic [1:0] mode,
                          input logic [TAG_W-1:0] tag);
        sign_i     = sgn;
        nar_i      = nar;
        zero_i     = zro;
        scale_i    = SW'(scale);
        mant_i     = mant;
        sticky_i   = stk;
        rnd_mode_i = mode;
        tag_i      = tag;
        in_valid_i = 1'b1;
    endtask

    task automatic accept_wait(input string name);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk_i);
            acc = in_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        check({name, "_accept"}, acc, 1);
    endtask

    task automatic send_one(input string name, input logic sgn, input logic nar,
                            input logic zro, input int scale, input logic [31:0] mant,
                            input logic stk, input logic [1:0] mode,
                            input logic [31:0] exp_res, input logic exp_inx);
        int n;
        set_op(sgn, nar, zro, scale, mant, stk, mode, tag_ctr);
        tag_ctr = tag_ctr + 1'b1;
        accept_wait(name);
        in_valid_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!out_valid_o && n < 50);
        check({name, "_latency"}, n, NUM_PIPE);
        check({name, "_res"}, result_o, exp_res);
        check({name, "_inexact"}, inexact_o, exp_inx);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int   idx, cyc, n, acc_cnt;
        logic ready_s, drop_seen;
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        sign_i = 1'b0; nar_i = 1'b0; zero_i = 1'b0; scale_i = '0; mant_i = '0;
        sticky_i = 1'b0; rnd_mode_i = 2'b00; tag_i = '0; tag_ctr = 4'd1;
        #23 rst_ni = 1'b1;

        @(negedge clk_i);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_inexact", inexact_o, 0);
        check("rst_tag", tag_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        @(posedge clk_i);
        #1;

        send_one("one_rne",        0, 0, 0,    0, 32'h0,        0, 2'd0, 32'h40000000, 0);
        send_one("neg_one",        1, 0, 0,    0, 32'h0,        0, 2'd0, 32'hC0000000, 0);
        send_one("tie_even",       0, 0, 0,    0, 32'h10,       0, 2'd0, 32'h40000000, 1);
        send_one("tie_pinf",       0, 0, 0,    0, 32'h10,       0, 2'd3, 32'h40000001, 1);
        send_one("tie_odd",        0, 0, 0,    0, 32'h30,       0, 2'd0, 32'h40000002, 1);
        send_one("rtz",            0, 0, 0,    0, 32'h1F,       0, 2'd1, 32'h40000000, 1);
        send_one("ninf_neg",       1, 0, 0,    0, 32'h10,       0, 2'd2, 32'hBFFFFFFF, 1);
        send_one("sticky_pinf",    0, 0, 0,    0, 32'h0,        1, 2'd3, 32'h40000001, 1);
        send_one("sticky_rne",     0, 0, 0,    0, 32'h0,        1, 2'd0, 32'h40000000, 1);
        send_one("half",           0, 0, 0,   -1, 32'h0,        0, 2'd0, 32'h38000000, 0);
        send_one("carry",          0, 0, 0,    3, 32'hFFFFFFFF, 0, 2'd0, 32'h60000000, 1);
        send_one("sat_hi",         0, 0, 0,  200, 32'h0,        0, 2'd0, 32'h7FFFFFFF, 1);
        send_one("sat_hi_pinf",    0, 0, 0,  200, 32'h0,        0, 2'd3, 32'h7FFFFFFF, 1);
        send_one("sat_lo",         0, 0, 0, -200, 32'h0,        0, 2'd0, 32'h00000001, 1);
        send_one("sat_lo_neg",     1, 0, 0, -200, 32'h0,        0, 2'd0, 32'hFFFFFFFF, 1);
        send_one("kmax_edge",      0, 0, 0,  116, 32'h0,        0, 2'd0, 32'h7FFFFFFE, 0);
        send_one("kmax_edge_pinf", 0, 0, 0,  116, 32'h0,        1, 2'd3, 32'h7FFFFFFF, 1);
        send_one("ksat_hi_edge",   0, 0, 0,  120, 32'h0,        0, 2'd0, 32'h7FFFFFFF, 1);
        send_one("kmin_edge",      0, 0, 0, -120, 32'h0,        0, 2'd0, 32'h00000001, 0);
        send_one("ksat_lo_edge",   0, 0, 0, -124, 32'h0,        0, 2'd0, 32'h00000001, 1);
        send_one("nar_zero",       0, 1, 1,    7, 32'h1234,     1, 2'd0, 32'h80000000, 0);
        send_one("zero",           1, 0, 1,    7, 32'h1234,     1, 2'd3, 32'h00000000, 0);

        // Backpressure: 8 ops against 5 stalled output cycles.
        got_tags.delete();
        out_ready_i = 1'b0;
        idx = 0; cyc = 0; acc_cnt = 0; drop_seen = 1'b0;
        while (idx < 8 && cyc < 200) begin
            set_op(idx[0], 0, 0, idx * 7 - 20, 32'h9E3779B9 * (idx + 1), idx[1],
                   idx[1:0], TAG_W'(idx));
            @(negedge clk_i);
            ready_s = in_ready_o;
            if (!ready_s && !drop_seen) begin
                drop_seen = 1'b1;
                check("bp_ready_drop_after", acc_cnt, 2);
            end
            @(posedge clk_i);
            #1;
            if (ready_s) begin
                idx++;
                acc_cnt++;
            end
            cyc++;
            out_ready_i = (cyc >= 5);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        check("bp_ready_dropped", drop_seen, 1);
        n = 0;
        while (got_tags.size() < 8 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1;
        check("bp_out_count", got_tags.size(), 8);
        for (int i = 0; i < got_tags.size() && i < 8; i++) check("bp_tag_order", got_tags[i], i);

        // Flush with two ops in flight; the input offered alongside flush is dropped.
        out_ready_i = 1'b0;
        set_op(0, 0, 0, 4, 32'h0, 0, 2'd0, 4'd1);
        accept_wait("fl_a");
        set_op(1, 0, 0, 9, 32'hABCD0000, 0, 2'd0, 4'd2);
        accept_wait("fl_b");
        check("fl_pre_valid", out_valid_o, 1);
        flush_i = 1'b1;
        set_op(0, 0, 0, 5, 32'h0, 0, 2'd0, 4'd3);
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("fl_out_valid", out_valid_o, 0);
        check("fl_in_ready", in_ready_o, 1);
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        send_one("post_flush", 0, 0, 0, 0, 32'h0, 0, 2'd0, 32'h40000000, 0);

        // Asynchronous reset mid-stream.
        out_ready_i = 1'b0;
        set_op(0, 0, 0, 0, 32'h10, 0, 2'd0, 4'd5);
        accept_wait("rs_a");
        set_op(0, 0, 0, 8, 32'h0, 0, 2'd0, 4'd6);
        accept_wait("rs_b");
        in_valid_i = 1'b0;
        check("rs_pre_valid", out_valid_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        check("rs_out_valid", out_valid_o, 0);
        check("rs_result", result_o, 0);
        check("rs_inexact", inexact_o, 0);
        check("rs_tag", tag_o, 0);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("rs_post_valid", out_valid_o, 0);
        check("rs_post_ready", in_ready_o, 1);
        @(posedge clk_i);
        #1;
        send_one("post_reset", 1, 0, 0, 0, 32'h30, 0, 2'd0, 32'hBFFFFFFE, 1);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/posit_round_pipe.md
Name: posit_round_pipe

Overview:
- Parametrised, pipelined posit encode-and-round stage at the output of the PPU arithmetic datapath (add/mul/div/fma).
- Takes a normalised sign/scale/fraction/sticky tuple and produces an N-bit posit.
- Supports four runtime rounding modes, saturates to maxpos/minpos, and reports inexact.
- Uses a valid/ready elastic pipeline with a tag sideband and a synchronous flush.

Parameters:
N, 32, posit width in bits (8..64).
ES, 2, exponent field width (0..4).
NUM_PIPE, 2, register stages, legal values 1 or 2; equals latency when not stalled.
TAG_W, 4, width of the opaque tag carried alongside each operation.
Derived: SW = $clog2(N)+ES+3, the width of the signed scale.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
flush_i  in  1  synchronous kill of all in-flight operations.
in_valid_i  in  1  input operation valid.
in_ready_o  out  1  block can accept an operation this cycle.
sign_i  in  1  result sign (1 = negative).
nar_i  in  1  result is NaR.
zero_i  in  1  result is zero.
scale_i  in  SW  signed binary scale: value = 2^scale_i * 1.mant_i.
mant_i  in  N  fraction bits after the hidden 1, MSB first.
sticky_i  in  1  OR of all fraction bits below mant_i.
rnd_mode_i  in  2  rounding mode: 00 RNE, 01 RTZ, 10 toward -inf, 11 toward +inf.
tag_i  in  TAG_W  opaque tag.
out_valid_o  out  1  result valid.
out_ready_i  in  1  downstream accepts the result.
result_o  out  N  encoded posit.
inexact_o  out  1  result differs from the exact input value.
tag_o  out  TAG_W  tag of the result.

Behaviour:
- Reset (async assert, sync release): all stage valids = 0; out_valid_o = 0; result_o = 0; inexact_o = 0; tag_o = 0. in_ready_o = 1 once reset is released.
- Handshake:
  - A transfer occurs when valid && ready.
  - A stage register loads when it is empty or its successor accepts, so bubbles collapse.
  - in_ready_o = !stage0_valid || stage0_advances.
  - Payload (result_o, inexact_o, tag_o) is held stable while out_valid_o && !out_ready_i.
  - Order is preserved. Latency is NUM_PIPE cycles from input transfer to out_valid_o when there is no stall.
- flush_i clears all valids next cycle and outranks a simultaneous input transfer (that input is dropped). in_ready_o may be 1 during flush.
- Decode: k = scale_i >>> ES (floor); e = scale_i[ES-1:0].
  - k >= 0: regime is k+1 ones then a 0.
  - k < 0: regime is -k zeros then a 1.
  - Bitstring after the sign bit = regime, e, mant_i, truncated to N-1 bits.
  - L = kept LSB; G = first dropped bit; S = OR of the rest of the dropped bits | sticky_i.
  - A terminating regime bit or exponent bit that falls past bit N-1 counts as a dropped bit.
- Saturation, before rounding (inexact = 1):
  - k >= N-2 gives maxpos magnitude (0 followed by N-1 ones).
  - k <= -(N-1) gives minpos magnitude (N-1 zeros, then 1).
- Rounding (magnitude increment inc):
  - RNE: inc = G & (L|S).
  - RTZ: inc = 0.
  - Toward -inf: inc = (G|S) & sign_i.
  - Toward +inf: inc = (G|S) & !sign_i.
  - Carry out of the fraction ripples into exponent/regime.
  - A magnitude equal to maxpos never increments to NaR.
  - A nonzero exact value never rounds to zero: minpos is the floor.
  - Directed modes on a saturated magnitude keep the saturated value.
- inexact_o = G|S, or saturation taken. inexact_o = 0 for zero/NaR.
- Sign: result_o = two's complement of the magnitude when sign_i = 1.
- Specials: nar_i gives 1 followed by N-1 zeros. zero_i gives all zeros. nar_i beats zero_i. Specials ignore mant_i and scale_i.
- Stage split (NUM_PIPE = 2):
  - Stage 0 registers the magnitude, inc, inexact, specials and tag.
  - Stage 1 registers the final result after increment and negation.
  - With NUM_PIPE = 1, all logic sits before a single register.
- Reset asserted mid-operation discards all in-flight data immediately.

Test Plan:
- N=32, ES=2, RNE: scale 0, mant 0, sticky 0 -> 0x40000000, inexact 0. Same input with sign 1 -> 0xC0000000.
- Tie handling: scale 0, mant 0x00000010 (G=1, L=0, S=0) -> RNE 0x40000000, inexact 1; +inf mode -> 0x40000001. mant 0x00000030 -> RNE 0x40000002.
- Saturation: scale +200 -> 0x7FFFFFFF, inexact 1. scale -200 -> 0x00000001. scale -200 with sign 1 -> 0xFFFFFFFF. +inf mode from maxpos never yields 0x80000000.
- Specials: nar_i=1 with zero_i=1 -> 0x80000000; zero_i alone -> 0x00000000; inexact 0 in both cases.
- Backpressure, NUM_PIPE=2: stream tags 0..7 with out_ready_i low for 5 cycles. in_ready_o drops after 2 transfers; results emerge tags 0..7 in order with none lost or duplicated; payload is stable while stalled.
- Flush and reset: flush_i with 2 ops in flight -> out_valid_o = 0 next cycle and the next input returns after NUM_PIPE cycles. rst_ni low mid-stream -> all outputs reach reset values asynchronously.
